// File: rtl/hbridge_drive_sequencer_if.sv
// ----------------------------------------------------------------------------
// hbridge_drive_sequencer_if
// Bundles the run/duty/direction/fault requests and the gate/status outputs
// of the H-bridge drive sequencer.
//   master : the controlling side (drives Enable, Duty, DirReq, Fault)
//   slave  : the sequencer (drives Signals, DirActive, PwmSynch, Busy,
//            FaultLatched)
// Signals encoding: bit3 = high-side A, bit2 = low-side A,
//                   bit1 = high-side B, bit0 = low-side B.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface hbridge_drive_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             Enable;
    logic [CNT_W-1:0] Duty;
    logic             DirReq;
    logic             Fault;
    logic [3:0]       Signals;
    logic             DirActive;
    logic             PwmSynch;
    logic             Busy;
    logic             FaultLatched;

    modport master (
        output Enable, Duty, DirReq, Fault,
        input  Signals, DirActive, PwmSynch, Busy, FaultLatched
    );

    modport slave (
        input  Enable, Duty, DirReq, Fault,
        output Signals, DirActive, PwmSynch, Busy, FaultLatched
    );
endinterface

// File: rtl/hbridge_drive_sequencer.sv
// ----------------------------------------------------------------------------
// hbridge_drive_sequencer
// PWM generator, direction sequencer and dead-time inserter sitting in front
// of the four H-bridge gate drivers.
// Ports:
//   Clock    : system clock, all logic on the rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : slave side of hbridge_drive_sequencer_if
//              Enable/Duty/DirReq/Fault in, Signals/DirActive/PwmSynch/
//              Busy/FaultLatched out
// Patterns: forward 1001, reverse 0110, brake/freewheel 0101, off 0000.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module hbridge_drive_sequencer #(
    parameter int CNT_W        = 8,
    parameter int DEAD_CYCLES  = 16,
    parameter int BRAKE_CYCLES = 1000
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    hbridge_drive_sequencer_if.slave bus
);
    localparam int DEAD_W  = 8;
    localparam int BRAKE_W = 20;

    localparam logic [DEAD_W-1:0]  DEAD_LOAD  = DEAD_W'(DEAD_CYCLES);
    localparam logic [BRAKE_W-1:0] BRAKE_LOAD = BRAKE_W'(BRAKE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    localparam logic [3:0] PAT_FWD   = 4'b1001;
    localparam logic [3:0] PAT_REV   = 4'b0110;
    localparam logic [3:0] PAT_BRAKE = 4'b0101;
    localparam logic [3:0] PAT_OFF   = 4'b0000;

    typedef enum logic [1:0] {IDLE, DRIVE, BRAKE, FAULT} state_t;

    state_t             state_reg,     state_next;
    logic               dir_reg,       dir_next;
    logic [BRAKE_W-1:0] brake_cnt_reg, brake_cnt_next;
    logic [DEAD_W-1:0]  dead_cnt_reg,  dead_cnt_next;
    logic [3:0]         signals_reg,   signals_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   duty_reg;
    logic               pwm_synch_reg;
    logic               pwm_on;
    logic [3:0]         target;

    // Duty is only taken at the end of a period so a period is never torn.
    assign pwm_on = (cnt_reg < duty_reg);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_reg       <= '0;
            duty_reg      <= '0;
            pwm_synch_reg <= 1'b0;
        end else begin
            cnt_reg       <= cnt_reg + 1'b1;
            pwm_synch_reg <= (cnt_reg == CNT_MAX);
            if (cnt_reg == CNT_MAX) begin
                duty_reg <= bus.Duty;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= IDLE;
            dir_reg       <= 1'b1;
            brake_cnt_reg <= '0;
            dead_cnt_reg  <= '0;
            signals_reg   <= PAT_OFF;
        end else begin
            state_reg     <= state_next;
            dir_reg       <= dir_next;
            brake_cnt_reg <= brake_cnt_next;
            dead_cnt_reg  <= dead_cnt_next;
            signals_reg   <= signals_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        dir_next       = dir_reg;
        brake_cnt_next = brake_cnt_reg;
        dead_cnt_next  = dead_cnt_reg;
        signals_next   = signals_reg;
        target         = PAT_OFF;

        case (state_reg)
            IDLE: begin
                target = PAT_OFF;
                if (bus.Enable) begin
                    state_next = DRIVE;
                    dir_next   = bus.DirReq;
                end
            end
            DRIVE: begin
                target = pwm_on ? (dir_reg ? PAT_FWD : PAT_REV) : PAT_BRAKE;
                if (!bus.Enable) begin
                    state_next = IDLE;
                end else if (bus.DirReq != dir_reg) begin
                    state_next     = BRAKE;
                    brake_cnt_next = BRAKE_LOAD;
                end
            end
            BRAKE: begin
                target = PAT_BRAKE;
                if (!bus.Enable) begin
                    state_next     = IDLE;
                    brake_cnt_next = '0;
                end else if (brake_cnt_reg == BRAKE_W'(1)) begin
                    // Direction is re-sampled at the end of the dwell; a
                    // request that reverted meanwhile leaves dir_reg as is.
                    state_next     = DRIVE;
                    dir_next       = bus.DirReq;
                    brake_cnt_next = '0;
                end else begin
                    brake_cnt_next = brake_cnt_reg - 1'b1;
                end
            end
            FAULT: begin
                target = PAT_OFF;
                if (!bus.Fault && !bus.Enable) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Dead-time insertion. A running interval is never restarted; the
        // final pattern is whatever the target is on its last clock.
        if (dead_cnt_reg != '0) begin
            dead_cnt_next = dead_cnt_reg - 1'b1;
            if (dead_cnt_reg == DEAD_W'(1)) begin
                signals_next = target;
            end
        end else if (target == signals_reg) begin
            signals_next = signals_reg;
        end else if ((signals_reg & target) == target) begin
            // Pure turn-off: no switch comes on, so no dead time needed.
            signals_next = target;
        end else begin
            signals_next  = signals_reg & target;
            dead_cnt_next = DEAD_LOAD;
        end

        // Fault overrides everything, including any running intervals.
        if (bus.Fault) begin
            state_next     = FAULT;
            signals_next   = PAT_OFF;
            dead_cnt_next  = '0;
            brake_cnt_next = '0;
        end
    end

    assign bus.Signals      = signals_reg;
    assign bus.DirActive    = dir_reg;
    assign bus.PwmSynch     = pwm_synch_reg;
    assign bus.Busy         = (state_reg == BRAKE) || (dead_cnt_reg != '0);
    assign bus.FaultLatched = (state_reg == FAULT);

endmodule

// File: tb/tb_hbridge_drive_sequencer.sv
// ----------------------------------------------------------------------------
// tb_hbridge_drive_sequencer
// Directed bench for hbridge_drive_sequencer with CNT_W=4, DEAD_CYCLES=4,
// BRAKE_CYCLES=20. A vector table covers PWM, duty update and reversal;
// hand-written sequences cover fault, asynchronous reset and a direction
// request that reverts during the brake dwell. A monitor watches for
// shoot-through on every cycle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hbridge_drive_sequencer;
    localparam int CNT_W = 4;
    localparam int NVEC  = 30;

    logic Clock;
    logic Reset_n;

    int checks;
    int errors;

    hbridge_drive_sequencer_if #(.CNT_W(CNT_W)) bus ();

    hbridge_drive_sequencer #(
        .CNT_W       (CNT_W),
        .DEAD_CYCLES (4),
        .BRAKE_CYCLES(20)
    ) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        int         n;
        logic       en;
        logic       dir;
        logic [3:0] duty;
        logic       flt;
        logic [3:0] sig;
        logic       da;
        logic       sy;
        logic       bz;
        logic       fl;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [3:0] sig,
                         input logic da, input logic sy, input logic bz,
                         input logic fl);
        logic [7:0] act;
        logic [7:0] exp;
        act = {bus.Signals, bus.DirActive, bus.PwmSynch, bus.Busy, bus.FaultLatched};
        exp = {sig, da, sy, bz, fl};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got sig=%b dir=%b sync=%b busy=%b flt=%b, want sig=%b dir=%b sync=%b busy=%b flt=%b",
                     name, act[7:4], act[3], act[2], act[1], act[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: sig=%b dir=%b sync=%b busy=%b flt=%b",
                     name, act[7:4], act[3], act[2], act[1], act[0]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Shoot-through monitor: a leg must never have both switches on.
    always @(negedge Clock) begin
        if (Reset_n) begin
            checks++;
            if ((bus.Signals[3] & bus.Signals[2]) | (bus.Signals[1] & bus.Signals[0])) begin
                errors++;
                $display("FAIL shoot_through: got sig=%b, want no leg with both switches on",
                         bus.Signals);
            end
        end
    end

    initial begin
        // Edge numbers in comments count rising edges after reset release.
        //          n  en dir duty  flt  sig     da sy bz fl
        vecs[0]  = '{1,  1, 1, 4'd6, 0, 4'b0000, 1, 0, 0, 0}; // E1  enter DRIVE
        vecs[1]  = '{1,  1, 1, 4'd6, 0, 4'b0000, 1, 0, 1, 0}; // E2  dead from off
        vecs[2]  = '{3,  1, 1, 4'd6, 0, 4'b0000, 1, 0, 1, 0}; // E5
        vecs[3]  = '{1,  1, 1, 4'd6, 0, 4'b0101, 1, 0, 0, 0}; // E6  brake pattern
        vecs[4]  = '{10, 1, 1, 4'd6, 0, 4'b0101, 1, 1, 0, 0}; // E16 wrap, duty taken
        vecs[5]  = '{1,  1, 1, 4'd6, 0, 4'b0001, 1, 0, 1, 0}; // E17 rising PWM edge
        vecs[6]  = '{3,  1, 1, 4'd6, 0, 4'b0001, 1, 0, 1, 0}; // E20
        vecs[7]  = '{1,  1, 1, 4'd6, 0, 4'b1001, 1, 0, 0, 0}; // E21 forward
        vecs[8]  = '{1,  1, 1, 4'd6, 0, 4'b1001, 1, 0, 0, 0}; // E22
        vecs[9]  = '{1,  1, 1, 4'd6, 0, 4'b0001, 1, 0, 1, 0}; // E23 falling edge
        vecs[10] = '{4,  1, 1, 4'd6, 0, 4'b0101, 1, 0, 0, 0}; // E27
        vecs[11] = '{5,  1, 1, 4'd10,0, 4'b0101, 1, 1, 0, 0}; // E32 duty change waits
        vecs[12] = '{1,  1, 1, 4'd10,0, 4'b0001, 1, 0, 1, 0}; // E33
        vecs[13] = '{4,  1, 1, 4'd10,0, 4'b1001, 1, 0, 0, 0}; // E37
        vecs[14] = '{5,  1, 1, 4'd10,0, 4'b1001, 1, 0, 0, 0}; // E42 longer on-time
        vecs[15] = '{1,  1, 1, 4'd10,0, 4'b0001, 1, 0, 1, 0}; // E43
        vecs[16] = '{4,  1, 1, 4'd10,0, 4'b0101, 1, 0, 0, 0}; // E47
        vecs[17] = '{1,  1, 1, 4'd0, 0, 4'b0101, 1, 1, 0, 0}; // E48 duty 0 taken
        vecs[18] = '{8,  1, 1, 4'd0, 0, 4'b0101, 1, 0, 0, 0}; // E56 never on
        vecs[19] = '{8,  1, 1, 4'd0, 0, 4'b0101, 1, 1, 0, 0}; // E64
        vecs[20] = '{21, 1, 1, 4'd6, 0, 4'b1001, 1, 0, 0, 0}; // E85 forward again
        vecs[21] = '{1,  1, 0, 4'd6, 0, 4'b1001, 1, 0, 1, 0}; // E86 BRAKE entered
        vecs[22] = '{1,  1, 0, 4'd6, 0, 4'b0001, 1, 0, 1, 0}; // E87 dead to brake
        vecs[23] = '{4,  1, 0, 4'd6, 0, 4'b0101, 1, 0, 1, 0}; // E91 brake dwell
        vecs[24] = '{14, 1, 0, 4'd6, 0, 4'b0101, 1, 0, 1, 0}; // E105 last brake clk
        vecs[25] = '{1,  1, 0, 4'd6, 0, 4'b0101, 0, 0, 0, 0}; // E106 reversed
        vecs[26] = '{7,  1, 0, 4'd6, 0, 4'b0100, 0, 0, 1, 0}; // E113 reverse rising
        vecs[27] = '{4,  1, 0, 4'd6, 0, 4'b0110, 0, 0, 0, 0}; // E117 reverse
        vecs[28] = '{2,  1, 0, 4'd6, 0, 4'b0100, 0, 0, 1, 0}; // E119
        vecs[29] = '{4,  1, 0, 4'd6, 0, 4'b0101, 0, 0, 0, 0}; // E123

        checks     = 0;
        errors     = 0;
        Reset_n    = 1'b0;
        bus.Enable = 1'b0;
        bus.Duty   = '0;
        bus.DirReq = 1'b1;
        bus.Fault  = 1'b0;

        step(3);
        check("reset", 4'b0000, 1, 0, 0, 0);
        Reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            bus.Enable = vecs[i].en;
            bus.DirReq = vecs[i].dir;
            bus.Duty   = vecs[i].duty;
            bus.Fault  = vecs[i].flt;
            step(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].sig, vecs[i].da,
                  vecs[i].sy, vecs[i].bz, vecs[i].fl);
        end

        // Fault in the middle of a dead interval.
        step(7);
        check("fault_pre_dead", 4'b0100, 0, 0, 1, 0);
        bus.Fault = 1'b1;
        step(1);
        check("fault_latched", 4'b0000, 0, 0, 0, 1);
        bus.Fault = 1'b0;
        step(3);
        check("fault_hold_enable", 4'b0000, 0, 0, 0, 1);
        bus.Enable = 1'b0;
        step(1);
        check("fault_exit_idle", 4'b0000, 0, 0, 0, 0);

        // Asynchronous reset while braking.
        bus.Enable = 1'b1;
        step(1);
        check("idle_to_drive", 4'b0000, 0, 0, 0, 0);
        bus.DirReq = 1'b1;
        step(1);
        check("brake_enter", 4'b0000, 0, 0, 1, 0);
        step(2);
        check("brake_busy", 4'b0000, 0, 0, 1, 0);
        #2 Reset_n = 1'b0;
        #1 check("async_reset", 4'b0000, 1, 0, 0, 0);
        bus.DirReq = 1'b0;
        #1 Reset_n = 1'b1;
        step(1);
        check("post_reset_drive", 4'b0000, 0, 0, 0, 0);
        step(1);
        check("post_reset_dead", 4'b0000, 0, 0, 1, 0);
        step(4);
        check("post_reset_duty0", 4'b0101, 0, 0, 0, 0);
        step(9);
        check("post_reset_nosync", 4'b0101, 0, 0, 0, 0);
        step(1);
        check("post_reset_sync", 4'b0101, 0, 1, 0, 0);

        // Direction request toggled away and back during the dwell.
        bus.DirReq = 1'b1;
        step(1);
        check("toggle_brake", 4'b0100, 0, 0, 1, 0);
        bus.DirReq = 1'b0;
        step(4);
        check("toggle_dwell", 4'b0101, 0, 0, 1, 0);
        step(15);
        check("toggle_full_dwell", 4'b0101, 0, 0, 1, 0);
        step(1);
        check("toggle_resume", 4'b0101, 0, 0, 0, 0);
        step(1);
        check("toggle_same_dir", 4'b0100, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hbridge_drive_sequencer.md
Name: hbridge_drive_sequencer

Overview:
- Controller in front of the 4-key H-bridge gate outputs. Generates PWM from a duty word and inserts per-switch dead time on every gate-pattern change.
- Sequences direction reversal through a timed low-side brake dwell, and latches external faults into a safe all-off state.
- Output pattern encoding: bit3 = high-side A, bit2 = low-side A, bit1 = high-side B, bit0 = low-side B.
  - Forward = 4'b1001, reverse = 4'b0110, freewheel/brake = 4'b0101, off = 4'b0000.

Parameters:
- CNT_W, 8: PWM counter width; PWM period = 2^CNT_W clocks.
- DEAD_CYCLES, 16: dead-time length in clocks. Legal range 1..255.
- BRAKE_CYCLES, 1000: brake dwell on reversal in clocks. Legal range 1..2^20-1.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- Enable  in  1  run request.
- Duty  in  CNT_W  PWM on-time in clocks per period.
- DirReq  in  1  requested direction: 1 = forward, 0 = reverse.
- Fault  in  1  synchronous fault input, active high.
- Signals  out  4  registered gate pattern.
- DirActive  out  1  direction currently applied.
- PwmSynch  out  1  one-clock pulse when the PWM counter is 0.
- Busy  out  1  high in BRAKE state or while a dead interval is running.
- FaultLatched  out  1  high in FAULT state.

Behaviour:
- Reset values: Signals=0, DirActive=1, PwmSynch=0, Busy=0, FaultLatched=0, state IDLE, counters 0, duty register 0.
- PWM counter:
  - Free-running CNT_W-bit up-counter that wraps from 2^CNT_W-1 to 0.
  - Duty is sampled into the duty register only on the cycle the counter is 2^CNT_W-1; it takes effect from count 0.
  - pwm_on = (cnt < duty register). Duty=0 gives pwm_on always 0; maximum on-time is 2^CNT_W-1 clocks per period.
  - PwmSynch is registered and is high for exactly the one clock in which cnt==0.
- State machine (IDLE, DRIVE, BRAKE, FAULT); per-state target pattern:
  - IDLE: target 0000. Enable=1 → DRIVE, and DirActive<=DirReq on that transition.
  - DRIVE: target is the forward or reverse pattern (per DirActive) when pwm_on=1, else 0101.
    - Enable=0 → IDLE.
    - DirReq != DirActive → BRAKE, with the brake counter loaded with BRAKE_CYCLES.
  - BRAKE: target 0101. The brake counter decrements each clock.
    - At count 1 → DRIVE, with DirActive<=DirReq sampled at that clock; if DirReq reverted meanwhile, DirActive is unchanged.
    - Enable=0 → IDLE immediately.
  - FAULT: target 0000. Exits to IDLE only when Fault=0 and Enable=0 on the same clock.
- Fault has priority in every state: on the clock after Fault=1 is sampled, Signals=0, state FAULT, and any dead or brake count is cleared.
- Dead-time insertion, evaluated each clock when not faulted:
  - target == Signals: hold.
  - target is a subset of Signals (turn-offs only, i.e. (Signals & target)==target): Signals<=target next clock, no dead time.
  - Otherwise: Signals<=Signals & target and the dead counter is loaded with DEAD_CYCLES. The intermediate pattern is held exactly DEAD_CYCLES clocks, then Signals<=target as sampled at the final clock.
  - Target changes during a dead interval do not restart the interval.
  - Consequence: any switch turning on has been off for at least DEAD_CYCLES clocks. Signals never has bits 3&2 or bits 1&0 high simultaneously.
- Latency: a target change at clock n gives the intermediate pattern at n+1 and the final pattern at n+1+DEAD_CYCLES.
- Reset asserted mid-operation forces all reset values immediately, without waiting for a clock edge.

Test Plan:
- CNT_W=4, DEAD_CYCLES=4, Enable=1, DirReq=1, Duty=6 → each 16-clock period:
  - Signals 0101 → 0001 for 4 clocks → 1001, held 6 clocks minus dead.
  - Falling PWM edge gives 0001 for 4 clocks → 0101.
  - PwmSynch pulses every 16 clocks.
- Reversal with BRAKE_CYCLES=20: toggle DirReq to 0 in DRIVE →
  - Busy=1 and Signals settles to 0101 through dead time, held for 20 clocks.
  - DirActive=0 afterwards, then the PWM pattern becomes 0110 with a 0100 intermediate.
  - Bits 3&2 and 1&0 are never high together.
- Duty changed from 6 to 10 mid-period → no change until the counter wraps; the next period shows the 10-clock on-time. Duty=0 → Signals stays 0101.
- Fault=1 in the middle of a dead interval → Signals=0000 and FaultLatched=1 next clock. Releasing Fault with Enable=1 keeps FAULT; Enable=0 with Fault=0 → IDLE.
- Reset_n pulsed low between clock edges during BRAKE → outputs take reset values immediately. After release with Enable=1 → DRIVE with DirActive=DirReq.
- DirReq toggled away and back within the brake dwell → the full brake runs, DirActive is unchanged, and DRIVE resumes in the original direction.
